// File: rtl/lcd_write_engine.sv
// lcd_write_engine: timed write sequencer for an HD44780-style character LCD.
// Accepts one byte per valid/ready handshake. It drives RS/RW/DATA, then
// produces a timed EN pulse and a hold period. It then waits out the
// controller execution time before accepting the next byte.
// lcd_o packing matches the LCD output register: {EN, RS, RW, DATA[7:0]}.
module lcd_write_engine #(
  parameter int unsigned T_SETUP = 3,
  parameter int unsigned T_PW    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_LONG  = 82000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [10:0] lcd_o
);

  localparam int unsigned CW = $clog2(T_LONG + 1);

  // Each timed state is loaded with its full duration.
  // The state is left on the cycle the count reads one, so it lasts exactly that many cycles.
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP);
  localparam logic [CW-1:0] LD_PW    = CW'(T_PW);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC);
  localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            en_q;
  logic            rs_q;
  logic [7:0]      data_q;
  logic            done_q;

  logic [CW-1:0]   wait_ld_d;
  logic            cnt_last_d;

  // Pick the execution wait: clear (0x01) and home (0x02/0x03) need the long wait.
  always_comb begin
    wait_ld_d = LD_EXEC;
    if (!rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0)) begin
      wait_ld_d = LD_LONG;
    end else begin
      wait_ld_d = LD_EXEC;
    end
  end

  assign cnt_last_d  = (cnt_q == CNT_ONE);
  assign req_ready_o = rst_ni && (state_q == S_IDLE);
  assign busy_o      = !req_ready_o;
  assign done_o      = done_q;
  assign lcd_o       = {en_q, rs_q, 1'b0, data_q};

  // Write sequencer: state, shared down-counter and all registered pin outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          en_q <= 1'b0;
          if (req_valid_i) begin
            rs_q    <= req_rs_i;
            data_q  <= req_data_i;
            cnt_q   <= LD_SETUP;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_last_d) begin
            en_q    <= 1'b1;
            cnt_q   <= LD_PW;
            state_q <= S_PULSE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_PULSE: begin
          if (cnt_last_d) begin
            en_q    <= 1'b0;
            cnt_q   <= LD_HOLD;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_HOLD: begin
          if (cnt_last_d) begin
            cnt_q   <= wait_ld_d;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_WAIT: begin
          if (cnt_last_d) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          en_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine.
// Instance A uses shortened execution waits so that long-wait writes stay brief.
// Instance B uses the minimal override set (1,1,1,4,8).
module tb_lcd_write_engine;

  localparam int AS = 3, AP = 12, AH = 2, AE = 20, AL = 80;
  localparam int BS = 1, BP = 1,  BH = 1, BE = 4,  BL = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        rs;
  logic [7:0]  data;
  logic        sel;

  logic        valid_a, valid_b;
  logic        ready_a, busy_a, done_a;
  logic        ready_b, busy_b, done_b;
  logic [10:0] lcd_a, lcd_b;

  logic        ready_m, busy_m, done_m;
  logic [10:0] lcd_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign valid_a = valid && !sel;
  assign valid_b = valid && sel;
  assign ready_m = sel ? ready_b : ready_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign lcd_m   = sel ? lcd_b   : lcd_a;

  lcd_write_engine #(.T_SETUP(AS), .T_PW(AP), .T_HOLD(AH), .T_EXEC(AE), .T_LONG(AL)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid_a), .req_ready_o(ready_a),
    .req_rs_i(rs), .req_data_i(data), .busy_o(busy_a), .done_o(done_a), .lcd_o(lcd_a)
  );

  lcd_write_engine #(.T_SETUP(BS), .T_PW(BP), .T_HOLD(BH), .T_EXEC(BE), .T_LONG(BL)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid_b), .req_ready_o(ready_b),
    .req_rs_i(rs), .req_data_i(data), .busy_o(busy_b), .done_o(done_b), .lcd_o(lcd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one write on the selected instance and measure its whole sequence.
  // Must be called at a negedge. With chain set, valid stays high carrying the next byte.
  task automatic run(input string tag, input int s, input int p, input int h, input int w,
                     input logic rs_v, input logic [7:0] d_v, input bit expect_now,
                     input bit chain, input logic nrs, input logic [7:0] nd);
    int waited, en_first, en_last, en_cnt, busy_cnt, done_at;
    bit acc;
    rs = rs_v; data = d_v; valid = 1'b1;
    acc = 1'b0; waited = 0;
    for (int k = 0; k < 50; k++) begin
      if (ready_m) begin acc = 1'b1; break; end
      waited++;
      @(negedge clk);
    end
    chk({tag, " accept"}, 32'(acc), 32'd1);
    if (!acc) begin valid = 1'b0; return; end
    if (expect_now) chk({tag, " zero gap"}, 32'(waited), 32'd0);
    @(posedge clk); #1;
    if (chain) begin rs = nrs; data = nd; end else valid = 1'b0;
    en_first = -1; en_last = -1; en_cnt = 0; busy_cnt = 0; done_at = -1;
    for (int i = 1; i <= s + p + h + w + 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({tag, " fields"}, 32'(lcd_m[9:0]), 32'({rs_v, 1'b0, d_v}));
        chk({tag, " busy"}, 32'(busy_m), 32'd1);
      end
      if (lcd_m[10]) begin
        if (en_first < 0) en_first = i;
        en_last = i;
        en_cnt++;
      end
      if (!ready_m) busy_cnt++;
      if (done_m) begin done_at = i; break; end
    end
    chk({tag, " en start"}, 32'(en_first), 32'(s + 1));
    chk({tag, " en width"}, 32'(en_cnt), 32'(p));
    chk({tag, " en contiguous"}, 32'(en_last - en_first + 1), 32'(p));
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(s + p + h + w));
    chk({tag, " done cycle"}, 32'(done_at), 32'(s + p + h + w + 1));
    chk({tag, " ready at done"}, 32'(ready_m), 32'd1);
    chk({tag, " fields held"}, 32'(lcd_m[9:0]), 32'({rs_v, 1'b0, d_v}));
    if (!chain) begin
      @(negedge clk);
      chk({tag, " done single"}, 32'(done_m), 32'd0);
    end
  endtask

  initial begin
    int en_seen, d_seen;
    rst_n = 1'b0; valid = 1'b0; rs = 1'b0; data = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset lcd a", 32'(lcd_a), 32'h000);
    chk("reset lcd b", 32'(lcd_b), 32'h000);
    chk("reset done", 32'(done_a), 32'd0);
    chk("reset ready", 32'(ready_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd1);
    rst_n = 1'b1; #1;
    chk("ready after release", 32'(ready_a), 32'd1);
    @(negedge clk);

    // Instance A: decode of clear/home against ordinary commands and data.
    run("a data41",  AS, AP, AH, AE, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00);
    run("a clear01", AS, AP, AH, AL, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00);
    run("a home03",  AS, AP, AH, AL, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00);
    run("a home02",  AS, AP, AH, AL, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00);
    run("a cmd04",   AS, AP, AH, AE, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00);
    run("a cmd80",   AS, AP, AH, AE, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 8'h00);
    run("a cmd00",   AS, AP, AH, AE, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    run("a data01",  AS, AP, AH, AE, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00);

    // Back-to-back: valid held high, the second byte is taken in the done cycle.
    run("a chain1",  AS, AP, AH, AE, 1'b1, 8'h48, 1'b1, 1'b1, 1'b1, 8'h49);
    run("a chain2",  AS, AP, AH, AE, 1'b1, 8'h49, 1'b1, 1'b0, 1'b0, 8'h00);

    // Reset while EN is high aborts the write without a done pulse.
    rs = 1'b1; data = 8'h55; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    en_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (lcd_a[10]) begin en_seen = 1; break; end
    end
    chk("abort en reached", 32'(en_seen), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort lcd", 32'(lcd_a), 32'h000);
    chk("abort done", 32'(done_a), 32'd0);
    chk("abort ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("abort ready release", 32'(ready_a), 32'd1);
    d_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_a) d_seen = 1;
    end
    chk("abort no done", 32'(d_seen), 32'd0);
    run("a after abort", AS, AP, AH, AE, 1'b1, 8'h5a, 1'b1, 1'b0, 1'b0, 8'h00);

    // Instance B: minimal timings.
    sel = 1'b1;
    @(negedge clk);
    run("b clear01", BS, BP, BH, BL, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00);
    run("b cmd30",   BS, BP, BH, BE, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
    run("b data02",  BS, BP, BH, BE, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h02);
    run("b home02",  BS, BP, BH, BL, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
